// File: rtl/vga_timing_counter.sv
// VGA raster timing: clock-enable divider, pixel/line counters, region and
// end-of-line/frame flags, and a wrapping completed-frame counter.
module vga_timing_counter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_PULSE  = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_PULSE  = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       active,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0]      H_ACT_W  = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACT_W  = 11'(V_ACTIVE);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_range
        $error("vga_timing_counter: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_div_range
        $error("vga_timing_counter: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    always_comb begin
        div_d       = div_q;
        pix_en_d    = 1'b0;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        frame_cnt_d = frame_cnt_q;
        if (en) begin
            div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            pix_en_d = (div_q == DIV_LAST);
            // Positions advance on the edge that consumes the registered strobe.
            if (pix_en_q) begin
                if (hcount_q == H_LAST) begin
                    hcount_d = '0;
                    if (vcount_q == V_LAST) begin
                        vcount_d    = '0;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end else begin
                        vcount_d = vcount_q + 10'd1;
                    end
                end else begin
                    hcount_d = hcount_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            pix_en_q    <= 1'b0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            div_q       <= div_d;
            pix_en_q    <= pix_en_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pix_en    = pix_en_q;
    assign hcount    = hcount_q;
    assign vcount    = vcount_q;
    assign frame_cnt = frame_cnt_q;
    assign active    = ({1'b0, hcount_q} < H_ACT_W) && ({1'b0, vcount_q} < V_ACT_W);
    assign line_end  = pix_en_q && en && (hcount_q == H_LAST);
    assign frame_end = line_end && (vcount_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_counter.sv
// Directed bench for vga_timing_counter: default timing plus two small
// overrides (CLK_DIV=1 10x4 raster, CLK_DIV=3 7x5 raster).
module tb_vga_timing_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default instance
    logic       rst_d, en_d;
    logic       pe_d, act_d, le_d, fe_d;
    logic [9:0] h_d, v_d;
    logic [7:0] fc_d;

    vga_timing_counter u_def (
        .clk(clk), .rst(rst_d), .en(en_d), .pix_en(pe_d), .hcount(h_d),
        .vcount(v_d), .active(act_d), .line_end(le_d), .frame_end(fe_d),
        .frame_cnt(fc_d)
    );

    // Small raster, CLK_DIV=1, H_TOTAL=10, V_TOTAL=4
    logic       rst_s, en_s;
    logic       pe_s, act_s, le_s, fe_s;
    logic [9:0] h_s, v_s;
    logic [7:0] fc_s;

    vga_timing_counter #(
        .H_ACTIVE(6), .H_FP(1), .H_PULSE(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_PULSE(1), .V_BP(0), .CLK_DIV(1)
    ) u_small (
        .clk(clk), .rst(rst_s), .en(en_s), .pix_en(pe_s), .hcount(h_s),
        .vcount(v_s), .active(act_s), .line_end(le_s), .frame_end(fe_s),
        .frame_cnt(fc_s)
    );

    // Small raster, CLK_DIV=3, H_TOTAL=7, V_TOTAL=5
    logic       rst_t, en_t;
    logic       pe_t, act_t, le_t, fe_t;
    logic [9:0] h_t, v_t;
    logic [7:0] fc_t;

    vga_timing_counter #(
        .H_ACTIVE(4), .H_FP(1), .H_PULSE(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_PULSE(1), .V_BP(1), .CLK_DIV(3)
    ) u_div3 (
        .clk(clk), .rst(rst_t), .en(en_t), .pix_en(pe_t), .hcount(h_t),
        .vcount(v_t), .active(act_t), .line_end(le_t), .frame_end(fe_t),
        .frame_cnt(fc_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs c edges after reset release with en held high
    // (c=0 is the reset state). Packed as {pix_en,h,v,active,line_end,frame_end,frame_cnt}.
    function automatic logic [31:0] model(input int c, input int div, input int htot,
                                          input int vtot, input int hact, input int vact);
        int p, h, v, fc;
        logic pe, le, fe, act;
        p   = (c == 0) ? 0 : (c - 1) / div;
        pe  = (c > 0) && (c % div == 0);
        h   = p % htot;
        v   = (p / htot) % vtot;
        fc  = (p / (htot * vtot)) % 256;
        le  = pe && (h == htot - 1);
        fe  = le && (v == vtot - 1);
        act = (h < hact) && (v < vact);
        return {pe, 10'(h), 10'(v), act, le, fe, 8'(fc)};
    endfunction

    task automatic test_reset();
        logic [31:0] got, exp;
        en_d = 1'b0; rst_d = 1'b1;
        tick(); tick();
        got = {pe_d, h_d, v_d, act_d, le_d, fe_d, fc_d};
        exp = {1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_en0 got=%h exp=%h", got, exp);
        end
        en_d = 1'b1;
        tick();
        got = {pe_d, h_d, v_d, act_d, le_d, fe_d, fc_d};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL reset_en1 got=%h exp=%h", got, exp);
        end
        rst_d = 1'b0;
        tick();
        checks++;
        if (pe_d !== 1'b0) begin
            errors++; $display("FAIL first_strobe_early pix_en=%b exp=0", pe_d);
        end
        tick();
        checks++;
        if (pe_d !== 1'b1 || h_d !== 10'd0) begin
            errors++; $display("FAIL first_strobe pix_en=%b h=%0d exp pix_en=1 h=0", pe_d, h_d);
        end
    endtask

    // Continues from c=2 of test_reset through two full lines.
    task automatic test_line();
        logic [31:0] got, exp;
        int le_count = 0;
        for (int c = 3; c <= 3201; c++) begin
            tick();
            got = {pe_d, h_d, v_d, act_d, le_d, fe_d, fc_d};
            exp = model(c, 2, 800, 525, 640, 480);
            if (le_d === 1'b1) le_count++;
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL line c=%0d got=%h exp=%h", c, got, exp);
            end
        end
        checks++;
        if (le_count != 2) begin
            errors++; $display("FAIL line_end_count got=%0d exp=2", le_count);
        end
        checks++;
        if (h_d !== 10'd0 || v_d !== 10'd2) begin
            errors++; $display("FAIL line_wrap h=%0d v=%0d exp h=0 v=2", h_d, v_d);
        end
    endtask

    task automatic test_freeze();
        int bad = 0;
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        for (int c = 1; c <= 247; c++) tick();
        checks++;
        if (h_d !== 10'd123 || pe_d !== 1'b0) begin
            errors++; $display("FAIL freeze_pre h=%0d pix_en=%b exp h=123 pix_en=0", h_d, pe_d);
        end
        en_d = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick();
            if (h_d !== 10'd123 || pe_d !== 1'b0 || le_d !== 1'b0 || v_d !== 10'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL freeze_hold bad_cycles=%0d exp=0 (h=%0d pix_en=%b)", bad, h_d, pe_d);
        end
        en_d = 1'b1;
        tick(); tick();
        checks++;
        if (h_d !== 10'd124) begin
            errors++; $display("FAIL freeze_resume h=%0d exp=124", h_d);
        end
        tick(); tick();
        checks++;
        if (h_d !== 10'd125) begin
            errors++; $display("FAIL freeze_no_skip h=%0d exp=125", h_d);
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] got, exp;
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        for (int c = 1; c <= 3001; c++) tick();
        got = {pe_d, h_d, v_d, act_d, le_d, fe_d, fc_d};
        exp = model(3001, 2, 800, 525, 640, 480);
        checks++;
        if (got !== exp || h_d !== 10'd700 || v_d !== 10'd1) begin
            errors++; $display("FAIL mid_pre got=%h exp=%h", got, exp);
        end
        rst_d = 1'b1;
        tick();
        got = {pe_d, h_d, v_d, act_d, le_d, fe_d, fc_d};
        exp = {1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
        checks++;
        if (got !== exp) begin
            errors++; $display("FAIL mid_reset got=%h exp=%h", got, exp);
        end
        rst_d = 1'b0;
    endtask

    task automatic test_small_frames();
        logic [31:0] got, exp;
        int fe_count = 0;
        int vmax = 0, hmax = 0;
        rst_s = 1'b1; en_s = 1'b1; tick(); rst_s = 1'b0;
        for (int c = 0; c <= 10281; c++) begin
            if (c > 0) tick();
            got = {pe_s, h_s, v_s, act_s, le_s, fe_s, fc_s};
            exp = model(c, 1, 10, 4, 6, 2);
            if (fe_s === 1'b1) fe_count++;
            if (int'(h_s) > hmax) hmax = int'(h_s);
            if (int'(v_s) > vmax) vmax = int'(v_s);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL small c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 10240) begin
                checks++;
                if (fc_s !== 8'd255 || fe_s !== 1'b1) begin
                    errors++; $display("FAIL small_pre_wrap fc=%0d fe=%b exp fc=255 fe=1", fc_s, fe_s);
                end
            end
            if (c == 10241) begin
                checks++;
                if (fc_s !== 8'd0 || h_s !== 10'd0 || v_s !== 10'd0) begin
                    errors++; $display("FAIL small_wrap fc=%0d h=%0d v=%0d exp 0 0 0", fc_s, h_s, v_s);
                end
            end
        end
        checks++;
        if (fe_count != 257) begin
            errors++; $display("FAIL small_frame_count got=%0d exp=257", fe_count);
        end
        checks++;
        if (hmax != 9 || vmax != 3) begin
            errors++; $display("FAIL small_range hmax=%0d vmax=%0d exp 9 3", hmax, vmax);
        end
    endtask

    task automatic test_div3();
        logic [31:0] got, exp;
        rst_t = 1'b1; en_t = 1'b1; tick(); rst_t = 1'b0;
        for (int c = 0; c <= 215; c++) begin
            if (c > 0) tick();
            got = {pe_t, h_t, v_t, act_t, le_t, fe_t, fc_t};
            exp = model(c, 3, 7, 5, 4, 2);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL div3 c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    initial begin
        rst_d = 1'b1; en_d = 1'b0;
        rst_s = 1'b1; en_s = 1'b1;
        rst_t = 1'b1; en_t = 1'b1;
        #1;
        test_reset();
        test_line();
        test_freeze();
        test_rst_mid();
        test_small_frames();
        test_div3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_counter.md
VGA_TIMING_COUNTER -- requirements
Module: vga_timing_counter

Interface
REQ-001 Parameter list SHALL be, one per line: name, default, meaning.
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_PULSE, 96, horizontal sync width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch (lines)
  V_PULSE, 2, vertical sync width (lines)
  V_BP, 33, vertical back porch (lines)
  CLK_DIV, 2, clk cycles per pixel (>=1)
REQ-002 Port list SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  en  in  1  run enable; low freezes all state
  pix_en  out  1  one-clk pixel strobe
  hcount  out  10  horizontal pixel position, 0..H_TOTAL-1
  vcount  out  10  vertical line position, 0..V_TOTAL-1
  active  out  1  current position is in the visible region
  line_end  out  1  one-clk pulse on the last pixel of a line
  frame_end  out  1  one-clk pulse on the last pixel of a frame
  frame_cnt  out  8  completed-frame counter
REQ-003 Clocking and reset SHALL be: reset rst, synchronous, active-high; clock clk.
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_PULSE+H_BP (default 800).
REQ-005 V_TOTAL SHALL equal V_ACTIVE+V_FP+V_PULSE+V_BP (default 525).
REQ-006 Both H_TOTAL and V_TOTAL SHALL be <=1024; elaboration SHALL fail otherwise.

Function
REQ-007 Divider: internal counter div counts 0..CLK_DIV-1 on each clk while en=1, then wraps to 0.
REQ-008 pix_en SHALL be registered and high for exactly one clk per CLK_DIV clks: on the clk after div==CLK_DIV-1.
REQ-009 CLK_DIV=1 SHALL give pix_en high on every clk while en=1.
REQ-010 hcount and vcount SHALL change only on clk edges where pix_en=1 and en=1.
REQ-011 hcount SHALL increment by 1 per pixel and wrap from H_TOTAL-1 to 0.
REQ-012 vcount SHALL increment only on the hcount wrap edge, and SHALL wrap from V_TOTAL-1 to 0 on that edge.
REQ-013 active SHALL be combinational: (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
REQ-014 line_end SHALL be combinational: pix_en && en && hcount==H_TOTAL-1; it marks the edge on which hcount wraps.
REQ-015 frame_end SHALL be line_end && vcount==V_TOTAL-1.
REQ-016 frame_cnt SHALL increment on each frame_end edge, modulo 256 (255->0).
REQ-017 en=0 SHALL hold div, hcount, vcount and frame_cnt, and force pix_en to 0 on the next clk; resuming continues from the held values with no skipped pixel.
REQ-018 Outputs SHALL never exceed their range: hcount<=H_TOTAL-1, vcount<=V_TOTAL-1.
REQ-019 Latency from position (hcount,vcount) to any derived flag SHALL be 0 clks; downstream sync stages add their own register stage.

Reset
REQ-020 rst=1 SHALL take priority over en and over every counter event.
REQ-021 Reset values SHALL be: div=0, pix_en=0, hcount=0, vcount=0, frame_cnt=0; hence active=1, line_end=0, frame_end=0.
REQ-022 rst asserted mid-line or mid-frame SHALL restart at (0,0) on the next clk, with no line_end or frame_end emitted.
REQ-023 After rst is released, the first pix_en SHALL occur CLK_DIV clks later.

Verification
REQ-024 Defaults, en=1, rst pulsed for 1 clk -> pix_en on every 2nd clk; hcount reaches 799 then 0 while vcount goes 0->1; line_end high exactly once per 1600 clks.
REQ-025 Run a full frame -> frame_end once after 800*525*2=840000 clks; frame_cnt 0->1; (hcount,vcount)=(0,0) on the next edge; active low for hcount 640..799 and for vcount 480..524.
REQ-026 Preload 255 frames, run one more -> frame_cnt wraps 255->0 on the frame_end edge.
REQ-027 en=0 for 37 clks at hcount=123 -> hcount stays 123 and pix_en stays 0; after en=1, hcount reaches 124 within CLK_DIV clks.
REQ-028 rst asserted at (hcount,vcount)=(700,400) -> next clk shows (0,0), frame_cnt=0, and no line_end or frame_end pulse.
REQ-029 CLK_DIV=1, H_TOTAL=10, V_TOTAL=4 override -> frame_end every 40 clks; hcount and vcount never exceed 9 and 3.
